// File: rtl/seq_pipe_pkg.sv
// seq_pipe_pkg: shared constants and helpers for the seq_pipe block.
// S flag bit positions, default parameter values and the popcount width.
package seq_pipe_pkg;

  // Bit positions inside the 3-bit S result
  localparam int S_AND = 0;
  localparam int S_XOR = 1;
  localparam int S_OR  = 2;

  // Default data and event-counter widths
  localparam int W_DEF  = 8;
  localparam int CW_DEF = 8;

  // Bits needed to hold a popcount of a w-bit word (0..w inclusive)
  function automatic int pop_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_pipe_logic.sv
// seq_pipe_logic: purely combinational stage-1 functions of the registered
// word r and gate bit m: parity p, upper-bits-zero z, gate g, popcount pc.
module seq_pipe_logic
  import seq_pipe_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0]          r,
  input  logic                  m,
  output logic                  p,
  output logic                  z,
  output logic                  g,
  output logic [pop_w(W)-1:0]   pc
);

  localparam int PW = pop_w(W);

  assign p = ^r;
  assign z = ~|r[W-1:1];
  assign g = ~(r[0] & m) | ~(r[W-1] & m) | p;

  // Population count of r, accumulated bit by bit
  always_comb begin
    // NOTE: the default assignment before the loop keeps pc fully assigned on every path, so no latch is inferred; blocking '=' is right inside combinational logic.
    pc = '0;
    for (int i = 0; i < W; i++) begin
      pc = pc + PW'(r[i]);
    end
  end

endmodule

// File: rtl/seq_pipe.sv
// seq_pipe: two-stage valid/ready pipeline. Stage 1 registers the accepted
// word and gate bit, stage 2 registers the derived flags and popcount.
// Optional feature: define SEQ_PIPE_EVT_CNT_EN to build the saturating
// counter of S[2] output transfers; otherwise EVT_CNT is tied to zero.
module seq_pipe
  import seq_pipe_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = CW_DEF
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [W-1:0]          I,
  input  logic                  MASK,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [2:0]            S,
  output logic [pop_w(W)-1:0]   POP,
  input  logic                  CNT_CLR,
  output logic [CW-1:0]         EVT_CNT
);

  localparam int PW = pop_w(W);

  // Stage 1 registers
  logic [W-1:0]  r1;
  logic          m1;
  logic          v1;

  // Stage 2 registers
  logic          p2;
  logic          z2;
  logic          g2;
  logic [PW-1:0] pop2;
  logic          v2;

  // Stage-1 function outputs
  logic          p;
  logic          z;
  logic          g;
  logic [PW-1:0] pc;

  // Handshake terms
  logic          en2;
  logic          accept;
  logic          xfer;
  logic          s_xor;

  seq_pipe_logic #(.W(W)) u_logic (
    .r  (r1),
    .m  (m1),
    .p  (p),
    .z  (z),
    .g  (g),
    .pc (pc)
  );

  // Stage 2 loads when it is empty or its word is leaving this cycle
  assign en2      = v1 & (~v2 | OUT_READY);
  assign IN_READY = ~v1 | en2;
  assign accept   = IN_VALID & IN_READY;
  assign xfer     = v2 & OUT_READY;

  // Outputs come straight from stage-2 registers
  assign s_xor       = p2 ^ g2;
  assign S[S_AND]    = p2 & z2;
  assign S[S_XOR]    = s_xor;
  assign S[S_OR]     = g2 | s_xor | ~(p2 & z2);
  assign POP         = pop2;
  assign OUT_VALID   = v2;

  // Stage 1: capture the word on acceptance, empty it when it moves on
  always_ff @(posedge CLK or negedge RST_N) begin
    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values and the pipeline shifts correctly regardless of block order.
    if (!RST_N) begin
      r1 <= '0;
      m1 <= 1'b0;
      v1 <= 1'b0;
    end else if (accept) begin
      r1 <= I;
      m1 <= MASK;
      v1 <= 1'b1;
    end else if (en2) begin
      v1 <= 1'b0;
    end
  end

  // Stage 2: take the stage-1 results on en2, empty on output transfer
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      p2   <= 1'b0;
      z2   <= 1'b0;
      g2   <= 1'b0;
      pop2 <= '0;
      v2   <= 1'b0;
    end else if (en2) begin
      p2   <= p;
      z2   <= z;
      g2   <= g;
      pop2 <= pc;
      v2   <= 1'b1;
    end else if (xfer) begin
      v2 <= 1'b0;
    end
  end

`ifdef SEQ_PIPE_EVT_CNT_EN
  logic [CW-1:0] evt_cnt;

  // Saturating count of transfers carrying S[2]; clear wins over increment
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      evt_cnt <= '0;
    end else if (CNT_CLR) begin
      evt_cnt <= '0;
    end else if (xfer && S[S_OR] && (evt_cnt != '1)) begin
      evt_cnt <= evt_cnt + CW'(1);
    end
  end

  assign EVT_CNT = evt_cnt;
`else
  // Counter not built: clear input is intentionally left without a load
  logic unused_cnt_clr;
  assign unused_cnt_clr = CNT_CLR;
  assign EVT_CNT        = '0;
`endif

endmodule
